slc3_button_conditioner: RTL and testbench

Conditions the raw active-low DE10-Lite pushbuttons (Run, Continue) before they reach the SLC-3 top level. Each button is synchronized with two flops and debounced by a per-button stability counter. The block then emits a debounced level and single-cycle press/release pulses, so the SLC-3 control FSM sees exactly one clean event per physical press. It sits directly upstream of the SLC-3 top, between the board pins and its Run/Continue inputs.

---
 rtl/slc3_btn_pkg.sv | 22 ++
 rtl/slc3_button_conditioner_if.sv | 25 ++
 rtl/btn_debounce_chan.sv | 105 ++++++++++
 rtl/slc3_button_conditioner.sv | 33 +++
 tb/tb_slc3_button_conditioner.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/slc3_btn_pkg.sv
// Shared constants, channel indices and event types for the SLC-3 pushbutton conditioner.
package slc3_btn_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;   // 10 ms at 50 MHz
  localparam int unsigned REPEAT_CYCLES_DEF   = 12500000; // 250 ms at 50 MHz

  localparam int unsigned BTN_RUN      = 0;
  localparam int unsigned BTN_CONTINUE = 1;

  typedef enum logic {
    BTN_RELEASED = 1'b0,
    BTN_PRESSED  = 1'b1
  } btn_state_t;

  // "release" is a reserved word, hence the suffixed field name.
  typedef struct packed {
    logic level;
    logic press;
    logic release_pulse;
  } btn_evt_t;

endpackage

// File: rtl/slc3_button_conditioner_if.sv
// Board-side pushbutton bundle: raw active-low buttons in, conditioned level/pulses out.
interface slc3_button_conditioner_if #(
  parameter int unsigned N_BTN = 2
);

  logic [N_BTN-1:0] btn_n_i;
  logic [N_BTN-1:0] btn_level_o;
  logic [N_BTN-1:0] btn_press_o;
  logic [N_BTN-1:0] btn_release_o;

  modport master (
    output btn_n_i,
    input  btn_level_o,
    input  btn_press_o,
    input  btn_release_o
  );

  modport slave (
    input  btn_n_i,
    output btn_level_o,
    output btn_press_o,
    output btn_release_o
  );

endinterface

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-flop synchronizer, stability counter, registered press/release pulses.
// Auto-repeat is compiled in only when BTNCOND_AUTOREPEAT_EN is defined.
module btn_debounce_chan
  import slc3_btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     btn_n,
  output btn_evt_t evt
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("btn_debounce_chan: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  logic          sync1, sync2;
  btn_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          press_nxt, release_nxt, press_d;
  logic          press_q, release_q;
  logic          sync_pressed;

  assign sync_pressed = ~sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      state     <= BTN_RELEASED;
      cnt       <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1     <= btn_n;
      sync2     <= sync1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      press_q   <= press_d;
      release_q <= release_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    if (sync_pressed == (state == BTN_PRESSED)) begin
      cnt_nxt = '0;
    end else if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      if (state == BTN_PRESSED) begin
        state_nxt   = BTN_RELEASED;
        release_nxt = 1'b1;
      end else begin
        state_nxt = BTN_PRESSED;
        press_nxt = 1'b1;
      end
    end else begin
      cnt_nxt = cnt + CW'(1);
    end
  end

`ifdef BTNCOND_AUTOREPEAT_EN
  localparam int unsigned   RW       = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rpt, rpt_nxt;
  logic          rpt_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rpt <= '0;
    else        rpt <= rpt_nxt;
  end

  // Counter only runs across edges where the button was already held and stays held,
  // so the accepted press itself restarts it and a release clears it.
  always_comb begin
    rpt_nxt  = '0;
    rpt_fire = 1'b0;
    if (state == BTN_PRESSED && state_nxt == BTN_PRESSED) begin
      if (rpt == RPT_LAST) begin
        rpt_fire = 1'b1;
      end else begin
        rpt_nxt = rpt + RW'(1);
      end
    end
  end

  assign press_d = press_nxt | rpt_fire;
`else
  assign press_d = press_nxt;
`endif

  assign evt.level         = (state == BTN_PRESSED);
  assign evt.press         = press_q;
  assign evt.release_pulse = release_q;

endmodule

// File: rtl/slc3_button_conditioner.sv
// Conditions the raw DE10-Lite Run/Continue pushbuttons for the SLC-3 top level.
// Optional auto-repeat via BTNCOND_AUTOREPEAT_EN (see btn_debounce_chan).
module slc3_button_conditioner
  import slc3_btn_pkg::*;
#(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  slc3_button_conditioner_if.slave   btn
);

  btn_evt_t evt [N_BTN];

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .clk   (Clk),
      .rst_n (Reset_n),
      .btn_n (btn.btn_n_i[i]),
      .evt   (evt[i])
    );

    assign btn.btn_level_o[i]   = evt[i].level;
    assign btn.btn_press_o[i]   = evt[i].press;
    assign btn.btn_release_o[i] = evt[i].release_pulse;
  end

endmodule

// File: tb/tb_slc3_button_conditioner.sv
// Self-checking bench for slc3_button_conditioner (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8).
module tb_slc3_button_conditioner;
  import slc3_btn_pkg::*;

  localparam int unsigned NB = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned R  = 8;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  slc3_button_conditioner_if #(.N_BTN(NB)) bif ();

  slc3_button_conditioner #(
    .N_BTN           (NB),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_CYCLES   (R)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .btn     (bif)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a delay line standing in for the synchronizer, and a window of
  // synced samples seen since the last accepted change.
  bit             m_pressed   [NB];
  bit             pipe        [NB][$];
  bit             win         [NB][$];
  int             since_press [NB];
  logic [NB-1:0]  exp_lvl, exp_prs, exp_rel;

  task automatic model_reset();
    for (int ch = 0; ch < NB; ch++) begin
      m_pressed[ch] = 1'b0;
      pipe[ch].delete();
      pipe[ch].push_back(1'b1);
      pipe[ch].push_back(1'b1);
      win[ch].delete();
      since_press[ch] = 0;
    end
    exp_lvl = '0;
    exp_prs = '0;
    exp_rel = '0;
  endtask

  task automatic model_edge(input logic [NB-1:0] raw);
    for (int ch = 0; ch < NB; ch++) begin
      bit s2, all_diff;
      s2 = pipe[ch].pop_front();
      pipe[ch].push_back(raw[ch]);
      exp_prs[ch] = 1'b0;
      exp_rel[ch] = 1'b0;
      win[ch].push_back(!s2);
      if (win[ch].size() > D) void'(win[ch].pop_front());
      all_diff = (win[ch].size() == D);
      for (int k = 0; k < win[ch].size(); k++)
        if (win[ch][k] == m_pressed[ch]) all_diff = 1'b0;
      if (all_diff) begin
        m_pressed[ch]   = !m_pressed[ch];
        win[ch].delete();
        since_press[ch] = 0;
        if (m_pressed[ch]) exp_prs[ch] = 1'b1;
        else               exp_rel[ch] = 1'b1;
      end
`ifdef BTNCOND_AUTOREPEAT_EN
      else if (m_pressed[ch]) begin
        since_press[ch]++;
        if (since_press[ch] == int'(R)) begin
          exp_prs[ch]     = 1'b1;
          since_press[ch] = 0;
        end
      end
`endif
      exp_lvl[ch] = m_pressed[ch];
    end
  endtask

  // Drive raw buttons just after an edge, advance one clock, sample 1 time unit later.
  task automatic step(input logic [NB-1:0] raw);
    bif.btn_n_i = raw;
    @(posedge Clk);
    if (Reset_n) model_edge(raw);
    #1;
  endtask

  task automatic test_reset();
    int fp;
    fp = -1;
    Reset_n     = 1'b0;
    bif.btn_n_i = 2'b00;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({bif.btn_level_o, bif.btn_press_o, bif.btn_release_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000000",
               {bif.btn_level_o, bif.btn_press_o, bif.btn_release_o});
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(2'b00);
      checks++;
      if ({bif.btn_level_o, bif.btn_press_o, bif.btn_release_o} !== {exp_lvl, exp_prs, exp_rel}) begin
        failures++;
        $display("FAIL reset_held k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=%b", k,
                 bif.btn_level_o, bif.btn_press_o, bif.btn_release_o, exp_lvl, exp_prs, exp_rel);
      end
      if (bif.btn_press_o == 2'b11 && fp < 0) fp = k;
    end
    checks++;
    if (fp != int'(D + 2) || bif.btn_level_o !== 2'b11) begin
      failures++;
      $display("FAIL reset_held_press_edge got edge=%0d lvl=%b exp edge=%0d lvl=11", fp, bif.btn_level_o, D + 2);
    end
    for (int k = 1; k <= int'(D + 4); k++) begin
      step(2'b11);
      checks++;
      if ({bif.btn_level_o, bif.btn_press_o, bif.btn_release_o} !== {exp_lvl, exp_prs, exp_rel}) begin
        failures++;
        $display("FAIL reset_release k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=%b", k,
                 bif.btn_level_o, bif.btn_press_o, bif.btn_release_o, exp_lvl, exp_prs, exp_rel);
      end
    end
  endtask

  task automatic test_clean_press();
    int fp, np, fr, nr;
    fp = -1; np = 0; fr = -1; nr = 0;
    for (int k = 1; k <= 12; k++) begin
      step(2'b10);
      checks++;
      if ({bif.btn_level_o, bif.btn_press_o, bif.btn_release_o} !== {exp_lvl, exp_prs, exp_rel}) begin
        failures++;
        $display("FAIL clean_press k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=%b", k,
                 bif.btn_level_o, bif.btn_press_o, bif.btn_release_o, exp_lvl, exp_prs, exp_rel);
      end
      if (bif.btn_press_o[BTN_RUN]) begin np++; if (fp < 0) fp = k; end
    end
    for (int k = 1; k <= 12; k++) begin
      step(2'b11);
      checks++;
      if ({bif.btn_level_o, bif.btn_press_o, bif.btn_release_o} !== {exp_lvl, exp_prs, exp_rel}) begin
        failures++;
        $display("FAIL clean_release k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=%b", k,
                 bif.btn_level_o, bif.btn_press_o, bif.btn_release_o, exp_lvl, exp_prs, exp_rel);
      end
      if (bif.btn_release_o[BTN_RUN]) begin nr++; if (fr < 0) fr = k; end
    end
    checks++;
    if (fp != int'(D + 2) || np != 1 || fr != int'(D + 2) || nr != 1) begin
      failures++;
      $display("FAIL clean_latency got press@%0d x%0d release@%0d x%0d exp press@%0d x1 release@%0d x1",
               fp, np, fr, nr, D + 2, D + 2);
    end
  endtask

  task automatic test_bounce();
    int nev, fp, np;
    logic [NB-1:0] raw;
    nev = 0; fp = -1; np = 0;
    for (int k = 0; k < 20; k++) begin
      raw = 2'b11;
      raw[BTN_CONTINUE] = ((k / 2) % 2) != 0;
      step(raw);
      checks++;
      if ({bif.btn_level_o, bif.btn_press_o, bif.btn_release_o} !== {exp_lvl, exp_prs, exp_rel}) begin
        failures++;
        $display("FAIL bounce k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=%b", k,
                 bif.btn_level_o, bif.btn_press_o, bif.btn_release_o, exp_lvl, exp_prs, exp_rel);
      end
      if (bif.btn_press_o != 0 || bif.btn_release_o != 0) nev++;
    end
    for (int k = 1; k <= 12; k++) begin
      step(2'b01);
      checks++;
      if ({bif.btn_level_o, bif.btn_press_o, bif.btn_release_o} !== {exp_lvl, exp_prs, exp_rel}) begin
        failures++;
        $display("FAIL bounce_settle k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=%b", k,
                 bif.btn_level_o, bif.btn_press_o, bif.btn_release_o, exp_lvl, exp_prs, exp_rel);
      end
      if (bif.btn_press_o[BTN_CONTINUE]) begin np++; if (fp < 0) fp = k; end
    end
    checks++;
    if (nev != 0 || fp != int'(D + 2) || np != 1) begin
      failures++;
      $display("FAIL bounce_events got bounce_events=%0d press@%0d x%0d exp 0 press@%0d x1", nev, fp, np, D + 2);
    end
    for (int k = 1; k <= int'(D + 4); k++) step(2'b11);
    checks++;
    if (bif.btn_level_o !== 2'b00) begin
      failures++;
      $display("FAIL bounce_idle got lvl=%b exp 00", bif.btn_level_o);
    end
  endtask

  task automatic test_glitch();
    int nev;
    nev = 0;
    for (int k = 0; k < 13; k++) begin
      step(k < 3 ? 2'b10 : 2'b11);
      checks++;
      if ({bif.btn_level_o, bif.btn_press_o, bif.btn_release_o} !== {exp_lvl, exp_prs, exp_rel}) begin
        failures++;
        $display("FAIL glitch k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=%b", k,
                 bif.btn_level_o, bif.btn_press_o, bif.btn_release_o, exp_lvl, exp_prs, exp_rel);
      end
      if (bif.btn_level_o != 0 || bif.btn_press_o != 0 || bif.btn_release_o != 0) nev++;
    end
    checks++;
    if (nev != 0) begin
      failures++;
      $display("FAIL glitch_quiet got active_cycles=%0d exp 0", nev);
    end
  endtask

  task automatic test_mid_count_reset();
    int fp;
    fp = -1;
    for (int k = 1; k <= int'(D + 4); k++) step(2'b01);
    for (int k = 1; k <= 5; k++) step(2'b00);
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({bif.btn_level_o, bif.btn_press_o, bif.btn_release_o} !== 6'b0) begin
      failures++;
      $display("FAIL midreset_async got=%b exp=000000",
               {bif.btn_level_o, bif.btn_press_o, bif.btn_release_o});
    end
    model_reset();
    step(2'b00);
    step(2'b00);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(2'b00);
      checks++;
      if ({bif.btn_level_o, bif.btn_press_o, bif.btn_release_o} !== {exp_lvl, exp_prs, exp_rel}) begin
        failures++;
        $display("FAIL midreset_recount k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=%b", k,
                 bif.btn_level_o, bif.btn_press_o, bif.btn_release_o, exp_lvl, exp_prs, exp_rel);
      end
      if (bif.btn_press_o != 0 && fp < 0) fp = k;
    end
    checks++;
    if (fp != int'(D + 2)) begin
      failures++;
      $display("FAIL midreset_press_edge got edge=%0d exp %0d", fp, D + 2);
    end
    for (int k = 1; k <= int'(D + 4); k++) step(2'b11);
  endtask

  task automatic test_autorepeat();
    int np, exp_np;
`ifdef BTNCOND_AUTOREPEAT_EN
    exp_np = 5;
`else
    exp_np = 1;
`endif
    np = 0;
    for (int k = 1; k <= int'(D + 2) + 39; k++) begin
      step(2'b01);
      checks++;
      if ({bif.btn_level_o, bif.btn_press_o, bif.btn_release_o} !== {exp_lvl, exp_prs, exp_rel}) begin
        failures++;
        $display("FAIL autorepeat k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=%b", k,
                 bif.btn_level_o, bif.btn_press_o, bif.btn_release_o, exp_lvl, exp_prs, exp_rel);
      end
      if (bif.btn_press_o[BTN_CONTINUE]) np++;
    end
    checks++;
    if (np != exp_np) begin
      failures++;
      $display("FAIL autorepeat_count got=%0d exp=%0d", np, exp_np);
    end
    for (int k = 1; k <= int'(D + 4); k++) step(2'b11);
  endtask

  task automatic test_random();
    logic [NB-1:0] cur;
    int rem [NB];
    cur = 2'b11;
    for (int ch = 0; ch < NB; ch++) rem[ch] = 0;
    for (int k = 0; k < 400; k++) begin
      for (int ch = 0; ch < NB; ch++) begin
        if (rem[ch] == 0) begin
          cur[ch] = ~cur[ch];
          rem[ch] = int'($urandom_range(1, 2 * D + 2));
        end
        rem[ch]--;
      end
      step(cur);
      checks++;
      if ({bif.btn_level_o, bif.btn_press_o, bif.btn_release_o} !== {exp_lvl, exp_prs, exp_rel}) begin
        failures++;
        $display("FAIL random k=%0d raw=%b got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=%b", k, cur,
                 bif.btn_level_o, bif.btn_press_o, bif.btn_release_o, exp_lvl, exp_prs, exp_rel);
      end
    end
    for (int k = 1; k <= int'(D + 4); k++) step(2'b11);
  endtask

  initial begin
    Reset_n     = 1'b0;
    bif.btn_n_i = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_mid_count_reset();
    test_autorepeat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
